// File: rtl/ozixe_ff_bank.sv
// Multi-bit OZIXE flip-flop bank: enable, sync/async reset values, scan chain,
// and a handshaked snapshot readback serializer (LSB chunk first).
module ozixe_ff_bank #(
    parameter int unsigned     WIDTH        = 8,
    parameter int unsigned     RB_W         = 4,
    parameter logic [WIDTH-1:0] ARST_VAL    = '0,
    parameter logic [WIDTH-1:0] SRST_VAL    = '0,
    parameter bit              CE_POL       = 1'b1,
    parameter bit              SRST_POL     = 1'b1,
    parameter bit              SRST_OVER_CE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ce_i,
    input  logic             srst_i,
    output logic [WIDTH-1:0] q_o,
    input  logic             scan_en_i,
    input  logic             scan_in_i,
    output logic             scan_out_o,
    input  logic             rb_req_i,
    output logic             rb_busy_o,
    output logic             rb_valid_o,
    input  logic             rb_ready_i,
    output logic [RB_W-1:0]  rb_data_o,
    output logic             rb_last_o
);

    localparam int unsigned NCHUNK = WIDTH / RB_W;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   scan_shift;
    logic               ce_act, srst_act;

    assign ce_act   = (ce_i == CE_POL);
    assign srst_act = (srst_i == SRST_POL);

    if (WIDTH == 1) begin : g_scan_w1
        assign scan_shift = scan_in_i;
    end else begin : g_scan_wn
        assign scan_shift = {q_q[WIDTH-2:0], scan_in_i};
    end

    always_comb begin
        q_d = q_q;
        if (scan_en_i) begin
            q_d = scan_shift;
        end else if (srst_act && (SRST_OVER_CE || ce_act)) begin
            q_d = SRST_VAL;
        end else if (ce_act) begin
            q_d = d_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (rb_req_i) begin
                    // Snapshot sees pre-edge q regardless of scan/srst at this edge.
                    shadow_d = q_q;
                    cnt_d    = '0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (rb_ready_i) begin
                    shadow_d = shadow_q >> RB_W;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q      <= ARST_VAL;
            shadow_q <= '0;
            cnt_q    <= '0;
            state_q  <= StIdle;
        end else begin
            q_q      <= q_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    assign q_o        = q_q;
    assign scan_out_o = q_q[WIDTH-1];
    assign rb_valid_o = (state_q == StSend);
    assign rb_busy_o  = (state_q == StSend);
    assign rb_data_o  = (state_q == StSend) ? shadow_q[RB_W-1:0] : '0;
    assign rb_last_o  = (state_q == StSend) && (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_ozixe_ff_bank.sv
// Directed bench for ozixe_ff_bank; a second instance covers srst gated by ce.
module tb_ozixe_ff_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] d = '0;
    logic       ce = 1'b0, srst = 1'b0, scan_en = 1'b0, scan_in = 1'b0;
    logic       rb_req = 1'b0, rb_ready = 1'b0;

    logic [7:0] q_a, q_b;
    logic       so_a, so_b;
    logic       busy_a, valid_a, last_a, busy_b, valid_b, last_b;
    logic [3:0] data_a, data_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ozixe_ff_bank #(
        .WIDTH(8), .RB_W(4), .ARST_VAL(8'hA5), .SRST_VAL(8'h3C),
        .CE_POL(1'b1), .SRST_POL(1'b1), .SRST_OVER_CE(1'b1)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .d_i(d), .ce_i(ce), .srst_i(srst), .q_o(q_a),
        .scan_en_i(scan_en), .scan_in_i(scan_in), .scan_out_o(so_a),
        .rb_req_i(rb_req), .rb_busy_o(busy_a), .rb_valid_o(valid_a),
        .rb_ready_i(rb_ready), .rb_data_o(data_a), .rb_last_o(last_a)
    );

    ozixe_ff_bank #(
        .WIDTH(8), .RB_W(4), .ARST_VAL(8'hA5), .SRST_VAL(8'h3C),
        .CE_POL(1'b1), .SRST_POL(1'b1), .SRST_OVER_CE(1'b0)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .d_i(d), .ce_i(ce), .srst_i(srst), .q_o(q_b),
        .scan_en_i(scan_en), .scan_in_i(scan_in), .scan_out_o(so_b),
        .rb_req_i(rb_req), .rb_busy_o(busy_b), .rb_valid_o(valid_b),
        .rb_ready_i(rb_ready), .rb_data_o(data_b), .rb_last_o(last_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();

        // 1: async reset mid-cycle, then enable
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", q_a, 8'hA5);
        chk("arst_valid", valid_a, 1'b0);
        chk("arst_busy", busy_a, 1'b0);
        chk("arst_data", data_a, 4'h0);
        chk("arst_last", last_a, 1'b0);
        #2 rst_n = 1'b1;
        d = 8'h5A; ce = 1'b0;
        step();
        chk("ce0_hold", q_a, 8'hA5);
        ce = 1'b1;
        step();
        chk("ce1_load", q_a, 8'h5A);
        chk("ce1_load_b", q_b, 8'h5A);

        // 2: sync reset priority over / under ce
        d = 8'hFF; ce = 1'b0; srst = 1'b1;
        step();
        chk("srst_over_ce", q_a, 8'h3C);
        chk("srst_gated_hold", q_b, 8'h5A);
        ce = 1'b1;
        step();
        chk("srst_gated_ce", q_b, 8'h3C);
        chk("srst_beats_d", q_a, 8'h3C);
        srst = 1'b0; ce = 1'b0;

        // 3: scan shift, scan beats srst
        d = 8'h81; ce = 1'b1;
        step();
        ce = 1'b0;
        chk("load_81", q_a, 8'h81);
        chk("scan_out_81", so_a, 1'b1);
        scan_en = 1'b1; scan_in = 1'b0;
        step();
        chk("scan1_q", q_a, 8'h02);
        chk("scan1_so", so_a, 1'b0);
        scan_in = 1'b1; srst = 1'b1;
        step();
        chk("scan2_q", q_a, 8'h05);
        chk("scan2_so", so_a, 1'b0);
        scan_en = 1'b0; srst = 1'b0; scan_in = 1'b0;

        // 4: readback with backpressure
        d = 8'hC7; ce = 1'b1;
        step();
        ce = 1'b0;
        rb_req = 1'b1;
        step();
        rb_req = 1'b0;
        chk("rb_valid0", valid_a, 1'b1);
        chk("rb_busy0", busy_a, 1'b1);
        chk("rb_data0", data_a, 4'h7);
        chk("rb_last0", last_a, 1'b0);
        rb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", valid_a, 1'b1);
            chk("bp_data", data_a, 4'h7);
            chk("bp_last", last_a, 1'b0);
        end
        rb_ready = 1'b1;
        step();
        chk("rb_data1", data_a, 4'hC);
        chk("rb_last1", last_a, 1'b1);
        step();
        chk("rb_done_valid", valid_a, 1'b0);
        chk("rb_done_busy", busy_a, 1'b0);
        rb_ready = 1'b0;

        // 5: register path and rb_req during SEND
        d = 8'h12; ce = 1'b1;
        step();
        rb_req = 1'b1; d = 8'hEE;
        step();
        rb_req = 1'b0;
        chk("conc_q", q_a, 8'hEE);
        chk("conc_data0", data_a, 4'h2);
        rb_req = 1'b1; rb_ready = 1'b1;
        step();
        rb_req = 1'b0;
        chk("conc_data1", data_a, 4'h1);
        chk("conc_last1", last_a, 1'b1);
        step();
        chk("conc_idle", valid_a, 1'b0);
        step();
        chk("conc_no_second", valid_a, 1'b0);
        rb_ready = 1'b0; ce = 1'b0;

        // 6: abort mid-readback, then read back the reset value
        rb_req = 1'b1;
        step();
        rb_req = 1'b0;
        chk("abort_pre_valid", valid_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", valid_a, 1'b0);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_q", q_a, 8'hA5);
        #2 rst_n = 1'b1;
        step();
        rb_req = 1'b1;
        step();
        rb_req = 1'b0;
        chk("post_data0", data_a, 4'h5);
        chk("post_last0", last_a, 1'b0);
        rb_ready = 1'b1;
        step();
        chk("post_data1", data_a, 4'hA);
        chk("post_last1", last_a, 1'b1);
        step();
        chk("post_idle", valid_a, 1'b0);
        rb_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ozixe_ff_bank.md
Name: ozixe_ff_bank

Overview:
- Parametrised multi-bit OZIXE flip-flop bank. Successor to the single-bit OZIXE_FF used as the uniform techmap target.
- Adds per-bank clock enable, synchronous reset with a programmable value, and a programmable asynchronous reset value.
- Adds a scan shift chain and a handshaked snapshot readback serializer.
- Sits between the FF techmap layer and the fabric. It is the target cell for the $_DFF*/$_SDFF*/$_DFFE*/$_SDFFE* families, and carries the configuration/debug readback path.

Parameters:
- WIDTH, 8, number of flip-flops in the bank (>=1).
- RB_W, 4, readback chunk width. WIDTH must be a multiple of RB_W.
- ARST_VAL, 0, WIDTH-bit value loaded on asynchronous reset.
- SRST_VAL, 0, WIDTH-bit value loaded on synchronous reset.
- CE_POL, 1, active level of ce.
- SRST_POL, 1, active level of srst.
- SRST_OVER_CE, 1, 1 = srst acts regardless of ce ($_SDFF* style); 0 = srst only acts when ce is active ($_SDFFCE* style).

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous reset, active-low.
- d, in, WIDTH, data input.
- ce, in, 1, clock enable, polarity set by CE_POL.
- srst, in, 1, synchronous reset, polarity set by SRST_POL.
- q, out, WIDTH, register output.
- scan_en, in, 1, scan shift mode.
- scan_in, in, 1, serial scan input into q[0].
- scan_out, out, 1, equals q[WIDTH-1].
- rb_req, in, 1, snapshot-and-readback request.
- rb_busy, out, 1, readback in progress.
- rb_valid, out, 1, rb_data valid.
- rb_ready, in, 1, consumer accepts the current chunk.
- rb_data, out, RB_W, current readback chunk.
- rb_last, out, 1, marks the final chunk.

Behaviour:

Clocking and reset:
- One clock domain. Reset is asynchronous and active-low.
- While rst_n=0:
  - q=ARST_VAL, shadow=0, chunk counter=0.
  - FSM=IDLE; rb_valid=0, rb_busy=0, rb_last=0, rb_data=0.
- Release of rst_n takes effect at the next rising clk edge.

Register update, evaluated each rising edge in strict priority order:
1. scan_en=1: q <= {q[WIDTH-2:0], scan_in}. For WIDTH=1, q <= scan_in. ce and srst are ignored.
2. srst active and (SRST_OVER_CE=1 or ce active): q <= SRST_VAL.
3. ce active: q <= d.
4. Otherwise q holds.

Register timing and rules:
- q updates one cycle after the edge; there is no combinational path from d to q.
- scan_out is q[WIDTH-1] directly (registered).
- Polarity parameters invert only the active level. They never change priority.

Readback FSM, states IDLE and SEND. NCHUNK = WIDTH/RB_W.
- IDLE:
  - If rb_req=1 at an edge: shadow <= q as it was before that edge's update, cnt <= 0, go to SEND.
  - rb_valid rises one cycle after the request edge.
- SEND:
  - rb_valid=1, rb_busy=1, rb_data=shadow[RB_W-1:0]. Chunks go out least-significant first.
  - rb_last=1 when cnt==NCHUNK-1.
  - On an edge with rb_ready=1: shadow >>= RB_W and cnt++. If cnt was NCHUNK-1, go to IDLE, so rb_valid=0 next cycle.
  - With rb_ready=0, rb_data, rb_last and rb_valid hold stable. Backpressure is unlimited.
- rb_req is ignored while in SEND. A new request is accepted no earlier than the first cycle back in IDLE.
- The register path keeps operating during readback (d, ce, srst, scan). The snapshot is unaffected.
- Simultaneous rb_req and scan_en/srst at the same edge: the snapshot takes pre-edge q.
- rst_n asserted mid-readback aborts it immediately. There is no partial completion; rb_valid drops asynchronously.
- NCHUNK=1: the single chunk has rb_last=1.

Test Plan:
Default config: WIDTH=8, RB_W=4, ARST_VAL=8'hA5, SRST_VAL=8'h3C, CE_POL=1, SRST_POL=1, SRST_OVER_CE=1, unless stated otherwise.
1. Reset and enable: assert rst_n=0 mid-cycle -> q=8'hA5 immediately. Release, d=8'h5A with ce=0 -> q stays A5. Set ce=1 -> q=5A the next cycle.
2. Sync reset priority: d=FF, ce=0, srst=1 -> q=3C. Rebuild with SRST_OVER_CE=0, apply ce=0, srst=1 -> q holds. Then ce=1, srst=1 -> q=3C.
3. Scan: q=8'h81, scan_en=1, scan_in=0,1 over two edges -> q=8'h05 after the second edge (after the first, 02 with scan_out 0). scan_en beats srst=1 at the same edge.
4. Readback with backpressure: q=8'hC7, pulse rb_req -> next cycle rb_valid=1, rb_data=4'h7, rb_last=0. Hold rb_ready=0 for 3 cycles -> outputs stable. Accept -> rb_data=4'hC, rb_last=1. Accept -> rb_valid=0, rb_busy=0.
5. Concurrency: start readback of 8'h12, then load ce/d=8'hEE and pulse rb_req during SEND -> chunks are still 2 then 1, and no second readback starts.
6. Abort: pull rst_n low while rb_valid=1 -> rb_valid=0 and q=A5 at once. After release, rb_req -> readback of A5 yields chunks 5, A.
